sporadic_arrival_shaper: RTL and testbench

Upstream environment stage for the two-machine scheduler benchmark. It turns raw nondeterministic request inputs into the scheduler's `start_a`, `start_b` and `tick` event inputs. It enforces a sporadic-task contract: at most one event per cycle, a minimum tick gap between successive arrivals of the same task, and a bounded total number of arrivals. Once the arrival budget is spent, only ticks pass, so the downstream scheduler can drain.

---
 rtl/sporadic_arrival_shaper_if.sv | 24 ++
 rtl/sporadic_arrival_shaper.sv | 75 +++++++
 tb/tb_sporadic_arrival_shaper.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sporadic_arrival_shaper_if.sv
// Request/grant bundle between the raw event source and the sporadic arrival shaper.
interface sporadic_arrival_shaper_if #(
  parameter int CNT_W = 4
);
  logic             req_a;
  logic             req_b;
  logic             req_tick;
  logic             start_a;
  logic             start_b;
  logic             tick;
  logic [CNT_W-1:0] arrivals;
  logic             exhausted;
  logic             dropped;

  modport master (
    output req_a, req_b, req_tick,
    input  start_a, start_b, tick, arrivals, exhausted, dropped
  );

  modport slave (
    input  req_a, req_b, req_tick,
    output start_a, start_b, tick, arrivals, exhausted, dropped
  );
endinterface

// File: rtl/sporadic_arrival_shaper.sv
// Shapes raw A/B/tick requests into sporadic scheduler events: one event per cycle,
// minimum tick gap per task, bounded arrival budget, then ticks only so the scheduler drains.
module sporadic_arrival_shaper #(
  parameter int MIN_GAP_A    = 3,
  parameter int MIN_GAP_B    = 3,
  parameter int GAP_W        = 4,
  parameter int MAX_ARRIVALS = 8,
  parameter int CNT_W        = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  sporadic_arrival_shaper_if.slave bus
);
  localparam logic [GAP_W-1:0] GAP_A_MAX = GAP_W'(MIN_GAP_A);
  localparam logic [GAP_W-1:0] GAP_B_MAX = GAP_W'(MIN_GAP_B);
  localparam logic [CNT_W-1:0] ARR_MAX   = CNT_W'(MAX_ARRIVALS);

  typedef enum logic [1:0] {WARM, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [GAP_W-1:0] gap_a, gap_b;
  logic [CNT_W-1:0] arrivals, arrivals_nxt;
  logic             exhausted, dropped;
  logic             elig_a, elig_b, grant_a, grant_b, grant_t, refuse;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= WARM;
    else        state <= state_nxt;
  end

  always_comb begin
    elig_a       = (state == RUN) && (gap_a >= GAP_A_MAX);
    elig_b       = (state == RUN) && (gap_b >= GAP_B_MAX);
    grant_a      = bus.req_a && elig_a;
    grant_b      = bus.req_b && elig_b && !grant_a;
    grant_t      = bus.req_tick && (state == RUN || state == DONE) && !grant_a && !grant_b;
    // A B request that only lost to A's priority is not a contract violation.
    refuse       = (state != WARM) &&
                   ((bus.req_a && !elig_a) || (bus.req_b && !elig_b && !grant_a));
    arrivals_nxt = arrivals + CNT_W'(grant_a | grant_b);
    state_nxt    = state;
    case (state)
      WARM:    state_nxt = (ARR_MAX == '0) ? DONE : RUN;
      RUN:     if (arrivals_nxt == ARR_MAX) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = WARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gap_a     <= GAP_A_MAX;
      gap_b     <= GAP_B_MAX;
      arrivals  <= '0;
      exhausted <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      // Gaps saturate at the minimum so a long idle never wraps back to "too soon".
      if (grant_a)      gap_a <= '0;
      else if (grant_t) gap_a <= (gap_a >= GAP_A_MAX) ? GAP_A_MAX : gap_a + 1'b1;
      if (grant_b)      gap_b <= '0;
      else if (grant_t) gap_b <= (gap_b >= GAP_B_MAX) ? GAP_B_MAX : gap_b + 1'b1;
      arrivals  <= arrivals_nxt;
      exhausted <= (arrivals_nxt == ARR_MAX);
      dropped   <= dropped | refuse;
    end
  end

  assign bus.start_a   = grant_a;
  assign bus.start_b   = grant_b;
  assign bus.tick      = grant_t;
  assign bus.arrivals  = arrivals;
  assign bus.exhausted = exhausted;
  assign bus.dropped   = dropped;
endmodule

// File: tb/tb_sporadic_arrival_shaper.sv
// Directed and random checks of sporadic_arrival_shaper (default budget 8, plus a budget-2 instance).
module tb_sporadic_arrival_shaper;
  localparam int MIN_A = 3;
  localparam int MIN_B = 3;
  localparam int MAX_M = 8;
  localparam int MAX_S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errs = 0;

  sporadic_arrival_shaper_if #(.CNT_W(4)) bus_m ();
  sporadic_arrival_shaper_if #(.CNT_W(4)) bus_s ();

  sporadic_arrival_shaper #(
    .MIN_GAP_A(MIN_A), .MIN_GAP_B(MIN_B), .GAP_W(4), .MAX_ARRIVALS(MAX_M), .CNT_W(4)
  ) dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m));

  sporadic_arrival_shaper #(
    .MIN_GAP_A(MIN_A), .MIN_GAP_B(MIN_B), .GAP_W(4), .MAX_ARRIVALS(MAX_S), .CNT_W(4)
  ) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want finish before it");
    $fatal(1, "watchdog");
  end

  task automatic idle_all();
    bus_m.req_a = 1'b0; bus_m.req_b = 1'b0; bus_m.req_tick = 1'b0;
    bus_s.req_a = 1'b0; bus_s.req_b = 1'b0; bus_s.req_tick = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  // Leaves both DUTs in their WARM cycle, just after the reset edge.
  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    bus_m.req_a = 1; bus_m.req_b = 1; bus_m.req_tick = 1;
    bus_s.req_a = 1; bus_s.req_b = 1; bus_s.req_tick = 1;
    @(negedge clk);
    checks++; if ({bus_m.start_a, bus_m.start_b, bus_m.tick} !== 3'b000) begin errs++; $display("FAIL reset_grants_m: got %b want 000", {bus_m.start_a, bus_m.start_b, bus_m.tick}); end
    checks++; if ({bus_s.start_a, bus_s.start_b, bus_s.tick} !== 3'b000) begin errs++; $display("FAIL reset_grants_s: got %b want 000", {bus_s.start_a, bus_s.start_b, bus_s.tick}); end
    checks++; if (bus_m.arrivals !== 4'd0) begin errs++; $display("FAIL reset_arrivals: got %0d want 0", bus_m.arrivals); end
    checks++; if (bus_m.exhausted !== 1'b0) begin errs++; $display("FAIL reset_exhausted: got %b want 0", bus_m.exhausted); end
    checks++; if (bus_m.dropped !== 1'b0) begin errs++; $display("FAIL reset_dropped: got %b want 0", bus_m.dropped); end
    next_cyc();
    idle_all();
    @(negedge clk);
    checks++; if (bus_m.dropped !== 1'b0) begin errs++; $display("FAIL warm_no_drop: got %b want 0", bus_m.dropped); end
  endtask

  task automatic test_hold_a();
    do_reset();
    bus_m.req_a = 1;
    @(negedge clk);
    checks++; if (bus_m.start_a !== 1'b0) begin errs++; $display("FAIL hold_a_c0: start_a=%b want 0", bus_m.start_a); end
    next_cyc(); @(negedge clk);
    checks++; if (bus_m.start_a !== 1'b1) begin errs++; $display("FAIL hold_a_c1: start_a=%b want 1", bus_m.start_a); end
    next_cyc(); @(negedge clk);
    checks++; if (bus_m.start_a !== 1'b0) begin errs++; $display("FAIL hold_a_c2: start_a=%b want 0", bus_m.start_a); end
    checks++; if (bus_m.dropped !== 1'b0) begin errs++; $display("FAIL hold_a_c2_drop: dropped=%b want 0", bus_m.dropped); end
    next_cyc(); @(negedge clk);
    checks++; if (bus_m.dropped !== 1'b1) begin errs++; $display("FAIL hold_a_c3_drop: dropped=%b want 1", bus_m.dropped); end
    checks++; if (bus_m.arrivals !== 4'd1) begin errs++; $display("FAIL hold_a_c3_arr: arrivals=%0d want 1", bus_m.arrivals); end
    idle_all();
  endtask

  task automatic test_gap();
    do_reset();
    next_cyc();
    bus_m.req_a = 1;
    @(negedge clk);
    checks++; if (bus_m.start_a !== 1'b1) begin errs++; $display("FAIL gap_first: start_a=%b want 1", bus_m.start_a); end
    next_cyc();
    bus_m.req_a = 0; bus_m.req_tick = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (bus_m.tick !== 1'b1) begin errs++; $display("FAIL gap_tick%0d: tick=%b want 1", i, bus_m.tick); end
      next_cyc();
    end
    bus_m.req_tick = 0; bus_m.req_a = 1;
    @(negedge clk);
    checks++; if (bus_m.start_a !== 1'b0) begin errs++; $display("FAIL gap_2ticks: start_a=%b want 0", bus_m.start_a); end
    next_cyc();
    bus_m.req_a = 0; bus_m.req_tick = 1;
    @(negedge clk);
    checks++; if (bus_m.dropped !== 1'b1) begin errs++; $display("FAIL gap_drop: dropped=%b want 1", bus_m.dropped); end
    next_cyc();
    bus_m.req_tick = 0; bus_m.req_a = 1;
    @(negedge clk);
    checks++; if (bus_m.start_a !== 1'b1) begin errs++; $display("FAIL gap_3ticks: start_a=%b want 1", bus_m.start_a); end
    next_cyc();
    // 16 ticks would wrap a 4-bit counter back to 0 if it did not saturate.
    bus_m.req_a = 0; bus_m.req_tick = 1;
    repeat (16) next_cyc();
    bus_m.req_tick = 0; bus_m.req_a = 1;
    @(negedge clk);
    checks++; if (bus_m.start_a !== 1'b1) begin errs++; $display("FAIL gap_saturate: start_a=%b want 1", bus_m.start_a); end
    next_cyc();
    idle_all();
  endtask

  task automatic test_priority();
    do_reset();
    next_cyc();
    bus_m.req_a = 1; bus_m.req_b = 1; bus_m.req_tick = 1;
    @(negedge clk);
    checks++; if ({bus_m.start_a, bus_m.start_b, bus_m.tick} !== 3'b100) begin errs++; $display("FAIL prio_abt: got %b want 100", {bus_m.start_a, bus_m.start_b, bus_m.tick}); end
    next_cyc();
    bus_m.req_a = 0;
    @(negedge clk);
    checks++; if ({bus_m.start_a, bus_m.start_b, bus_m.tick} !== 3'b010) begin errs++; $display("FAIL prio_bt: got %b want 010", {bus_m.start_a, bus_m.start_b, bus_m.tick}); end
    checks++; if (bus_m.dropped !== 1'b0) begin errs++; $display("FAIL prio_no_drop1: dropped=%b want 0", bus_m.dropped); end
    next_cyc();
    bus_m.req_b = 0;
    repeat (3) next_cyc();
    bus_m.req_tick = 0; bus_m.req_b = 1;
    @(negedge clk);
    checks++; if (bus_m.start_b !== 1'b1) begin errs++; $display("FAIL prio_b_again: start_b=%b want 1", bus_m.start_b); end
    next_cyc();
    bus_m.req_a = 1;
    @(negedge clk);
    checks++; if ({bus_m.start_a, bus_m.start_b, bus_m.tick} !== 3'b100) begin errs++; $display("FAIL prio_a_over_b: got %b want 100", {bus_m.start_a, bus_m.start_b, bus_m.tick}); end
    next_cyc();
    bus_m.req_a = 0; bus_m.req_b = 0;
    @(negedge clk);
    checks++; if (bus_m.dropped !== 1'b0) begin errs++; $display("FAIL prio_no_drop2: dropped=%b want 0", bus_m.dropped); end
    checks++; if (bus_m.arrivals !== 4'd4) begin errs++; $display("FAIL prio_arrivals: arrivals=%0d want 4", bus_m.arrivals); end
    bus_m.req_a = 1;
    #1;
    checks++; if (bus_m.start_a !== 1'b0) begin errs++; $display("FAIL prio_a_gap: start_a=%b want 0", bus_m.start_a); end
    next_cyc();
    bus_m.req_a = 0;
    @(negedge clk);
    checks++; if (bus_m.dropped !== 1'b1) begin errs++; $display("FAIL prio_drop: dropped=%b want 1", bus_m.dropped); end
    idle_all();
  endtask

  task automatic test_budget();
    do_reset();
    next_cyc();
    bus_s.req_a = 1;
    @(negedge clk);
    checks++; if (bus_s.start_a !== 1'b1) begin errs++; $display("FAIL budget_a: start_a=%b want 1", bus_s.start_a); end
    next_cyc();
    bus_s.req_a = 0; bus_s.req_b = 1;
    @(negedge clk);
    checks++; if (bus_s.start_b !== 1'b1) begin errs++; $display("FAIL budget_b: start_b=%b want 1", bus_s.start_b); end
    checks++; if ({bus_s.arrivals, bus_s.exhausted} !== {4'd1, 1'b0}) begin errs++; $display("FAIL budget_mid: arrivals=%0d exhausted=%b want 1/0", bus_s.arrivals, bus_s.exhausted); end
    next_cyc();
    bus_s.req_b = 0; bus_s.req_tick = 1;
    @(negedge clk);
    checks++; if ({bus_s.arrivals, bus_s.exhausted} !== {4'd2, 1'b1}) begin errs++; $display("FAIL budget_done: arrivals=%0d exhausted=%b want 2/1", bus_s.arrivals, bus_s.exhausted); end
    repeat (3) next_cyc();
    bus_s.req_a = 1; bus_s.req_b = 1;
    @(negedge clk);
    checks++; if ({bus_s.start_a, bus_s.start_b, bus_s.tick} !== 3'b001) begin errs++; $display("FAIL budget_refuse: got %b want 001", {bus_s.start_a, bus_s.start_b, bus_s.tick}); end
    checks++; if (bus_s.dropped !== 1'b0) begin errs++; $display("FAIL budget_pre_drop: dropped=%b want 0", bus_s.dropped); end
    next_cyc();
    idle_all();
    @(negedge clk);
    checks++; if ({bus_s.dropped, bus_s.arrivals} !== {1'b1, 4'd2}) begin errs++; $display("FAIL budget_drop: dropped=%b arrivals=%0d want 1/2", bus_s.dropped, bus_s.arrivals); end
  endtask

  task automatic test_midrun_reset();
    do_reset();
    next_cyc();
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) bus_m.req_a = 1; else bus_m.req_b = 1;
      @(negedge clk);
      checks++; if (((i % 2 == 0) ? bus_m.start_a : bus_m.start_b) !== 1'b1) begin errs++; $display("FAIL midrun_grant%0d: got 0 want 1", i); end
      next_cyc();
      bus_m.req_a = 0; bus_m.req_b = 0;
      if (i % 2 == 1) begin
        bus_m.req_tick = 1;
        repeat (3) next_cyc();
        bus_m.req_tick = 0;
      end
    end
    @(negedge clk);
    checks++; if (bus_m.arrivals !== 4'd5) begin errs++; $display("FAIL midrun_arr5: arrivals=%0d want 5", bus_m.arrivals); end
    bus_m.req_a = 1; bus_m.req_b = 1;
    rst_n = 0;
    next_cyc();
    rst_n = 1;
    @(negedge clk);
    checks++; if ({bus_m.start_a, bus_m.start_b, bus_m.tick} !== 3'b000) begin errs++; $display("FAIL midrun_warm: got %b want 000", {bus_m.start_a, bus_m.start_b, bus_m.tick}); end
    checks++; if ({bus_m.arrivals, bus_m.dropped, bus_m.exhausted} !== {4'd0, 1'b0, 1'b0}) begin errs++; $display("FAIL midrun_regs: arrivals=%0d dropped=%b exhausted=%b want 0/0/0", bus_m.arrivals, bus_m.dropped, bus_m.exhausted); end
    next_cyc();
    bus_m.req_b = 0;
    @(negedge clk);
    checks++; if (bus_m.start_a !== 1'b1) begin errs++; $display("FAIL midrun_a: start_a=%b want 1", bus_m.start_a); end
    next_cyc();
    bus_m.req_a = 0; bus_m.req_b = 1;
    @(negedge clk);
    checks++; if (bus_m.start_b !== 1'b1) begin errs++; $display("FAIL midrun_b: start_b=%b want 1", bus_m.start_b); end
    next_cyc();
    idle_all();
    @(negedge clk);
    checks++; if ({bus_m.dropped, bus_m.arrivals} !== {1'b0, 4'd2}) begin errs++; $display("FAIL midrun_after: dropped=%b arrivals=%0d want 0/2", bus_m.dropped, bus_m.arrivals); end
  endtask

  task automatic test_soak();
    int   ta, tb, cnt, sum;
    bit   warm, drp, ra, rb, rt, rs, alive, run, ela, elb, ea, eb, et;
    do_reset();
    warm = 1; drp = 0; cnt = 0; ta = MIN_A; tb = MIN_B;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      rs = ($urandom_range(299) != 0);
      ra = ($urandom_range(99) < 30);
      rb = ($urandom_range(99) < 30);
      rt = ($urandom_range(99) < 50);
      rst_n = rs; bus_m.req_a = ra; bus_m.req_b = rb; bus_m.req_tick = rt;
      @(negedge clk);
      alive = !warm;
      run   = alive && (cnt < MAX_M);
      ela   = run && (ta >= MIN_A);
      elb   = run && (tb >= MIN_B);
      ea    = ra && ela;
      eb    = rb && elb && !ea;
      et    = rt && alive && !ea && !eb;
      checks++; if ({bus_m.start_a, bus_m.start_b, bus_m.tick, bus_m.exhausted, bus_m.dropped} !== {ea, eb, et, (cnt == MAX_M), drp}) begin
        errs++; $display("FAIL soak_cyc%0d: a/b/t/exh/drop=%b want %b", cyc, {bus_m.start_a, bus_m.start_b, bus_m.tick, bus_m.exhausted, bus_m.dropped}, {ea, eb, et, (cnt == MAX_M), drp});
      end
      checks++; if (bus_m.arrivals !== 4'(cnt)) begin errs++; $display("FAIL soak_arr%0d: arrivals=%0d want %0d", cyc, bus_m.arrivals, cnt); end
      sum = int'(bus_m.start_a) + int'(bus_m.start_b) + int'(bus_m.tick);
      checks++; if (sum > 1 || int'(bus_m.arrivals) > MAX_M) begin errs++; $display("FAIL soak_inv%0d: grants=%0d arrivals=%0d want <=1 and <=%0d", cyc, sum, bus_m.arrivals, MAX_M); end
      if (!rs) begin
        warm = 1; drp = 0; cnt = 0; ta = MIN_A; tb = MIN_B;
      end else if (warm) begin
        warm = 0;
      end else begin
        drp = drp | (ra && !ela) | (rb && !elb && !ea);
        if (ea) begin ta = 0; cnt++; end
        if (eb) begin tb = 0; cnt++; end
        if (et) begin
          if (ta < 1000) ta++;
          if (tb < 1000) tb++;
        end
      end
      next_cyc();
    end
    rst_n = 1;
    idle_all();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_hold_a();
    test_gap();
    test_priority();
    test_budget();
    test_midrun_reset();
    test_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
